// File: rtl/unstriping_if.sv
// Lane-side and merged-side signals of the two-lane unstriping block.
// The lane producer drives through master; the unstriping block uses slave.
interface unstriping_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] lane_0;
    logic                  valid_0;
    logic [DATA_WIDTH-1:0] lane_1;
    logic                  valid_1;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  overflow;

    modport master (
        output lane_0, valid_0, lane_1, valid_1,
        input  data_out, valid_out, overflow
    );

    modport slave (
        input  lane_0, valid_0, lane_1, valid_1,
        output data_out, valid_out, overflow
    );
endinterface

// File: rtl/unstriping.sv
// Merges two independently-valid lanes back into one word stream, strictly alternating
// lane 0, lane 1, ..., with a small FIFO per lane to absorb inter-lane skew.
module unstriping #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk_2f,
    input  logic       reset,
    unstriping_if.slave bus
);
    // FIFO_DEPTH is a power of two, so pointers wrap by natural overflow.
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

    localparam logic SEL0 = 1'b0;
    localparam logic SEL1 = 1'b1;

    logic [DATA_WIDTH-1:0] mem_q [2][FIFO_DEPTH];

    logic [1:0][PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [1:0][PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [1:0][CntW-1:0]       cnt_q, cnt_d;
    logic [1:0][DATA_WIDTH-1:0] lane_data;
    logic [1:0]                 lane_valid;
    logic [1:0]                 pop;
    logic [1:0]                 push;
    logic [1:0]                 drop;

    logic                  state_q, state_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  overflow_q, overflow_d;

    always_comb begin
        lane_data  = {bus.lane_1, bus.lane_0};
        lane_valid = {bus.valid_1, bus.valid_0};

        // Only the selected lane may pop; the other waits even if it holds data.
        pop[0] = (state_q == SEL0) && (cnt_q[0] != '0);
        pop[1] = (state_q == SEL1) && (cnt_q[1] != '0);

        for (int i = 0; i < 2; i++) begin
            push[i] = lane_valid[i] && ((cnt_q[i] != CntFull) || pop[i]);
            drop[i] = lane_valid[i] && !push[i];

            wr_ptr_d[i] = push[i] ? wr_ptr_q[i] + PtrW'(1) : wr_ptr_q[i];
            rd_ptr_d[i] = pop[i]  ? rd_ptr_q[i] + PtrW'(1) : rd_ptr_q[i];

            cnt_d[i] = cnt_q[i];
            if (push[i] && !pop[i]) begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end else if (!push[i] && pop[i]) begin
                cnt_d[i] = cnt_q[i] - CntW'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        data_out_d  = '0;
        valid_out_d = 1'b0;
        case (state_q)
            SEL0: begin
                if (pop[0]) begin
                    data_out_d  = mem_q[0][rd_ptr_q[0]];
                    valid_out_d = 1'b1;
                    state_d     = SEL1;
                end
            end
            default: begin
                if (pop[1]) begin
                    data_out_d  = mem_q[1][rd_ptr_q[1]];
                    valid_out_d = 1'b1;
                    state_d     = SEL0;
                end
            end
        endcase
        overflow_d = overflow_q | (|drop);
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            state_q     <= SEL0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage needs no reset: the counts alone decide what is readable.
    always_ff @(posedge clk_2f) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset && push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= lane_data[i];
            end
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.valid_out = valid_out_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_unstriping.sv
// Directed, table-driven bench for unstriping: ordering, skew, starvation, overflow,
// full-with-pop and mid-stream reset.
module tb_unstriping;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] I     = 32'hDEADBEEF;

    typedef struct {
        logic        rst;
        logic        v0;
        logic [31:0] l0;
        logic        v1;
        logic [31:0] l1;
        logic        ev;
        logic [31:0] ed;
        logic        eo;
    } vec_t;

    logic clk_2f = 1'b0;
    logic reset  = 1'b1;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];

    always #5 clk_2f = ~clk_2f;

    unstriping_if #(.DATA_WIDTH(DW)) bus ();

    unstriping #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_2f(clk_2f),
        .reset (reset),
        .bus   (bus)
    );

    task automatic add(input logic rst, input logic v0, input logic [31:0] l0,
                       input logic v1, input logic [31:0] l1,
                       input logic ev, input logic [31:0] ed, input logic eo);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.l0 = l0; v.v1 = v1; v.l1 = l1;
        v.ev = ev; v.ed = ed; v.eo = eo;
        vecs.push_back(v);
    endtask

    task automatic apply(input logic rst, input logic v0, input logic [31:0] l0,
                         input logic v1, input logic [31:0] l1);
        reset       = rst;
        bus.valid_0 = v0;
        bus.lane_0  = l0;
        bus.valid_1 = v1;
        bus.lane_1  = l1;
        @(posedge clk_2f);
        #1;
    endtask

    task automatic check(input string name, input logic ev, input logic [31:0] ed,
                         input logic eo);
        checks++;
        if (bus.valid_out !== ev || bus.data_out !== ed || bus.overflow !== eo) begin
            errors++;
            $display("FAIL %s: got valid=%0b data=%h overflow=%0b, want valid=%0b data=%h overflow=%0b",
                     name, bus.valid_out, bus.data_out, bus.overflow, ev, ed, eo);
        end
    endtask

    initial begin
        // rst v0 l0 v1 l1 | valid data ovf
        add(1, 0, I, 0, I,                    0, 32'h0, 0);
        // In-order pairs
        add(0, 1, 32'hFFFFFFFF, 1, 32'hEEEEEEEE, 0, 32'h0, 0);
        add(0, 0, I, 0, I,                    1, 32'hFFFFFFFF, 0);
        add(0, 1, 32'hDDDDDDDD, 1, 32'hCCCCCCCC, 1, 32'hEEEEEEEE, 0);
        add(0, 0, I, 0, I,                    1, 32'hDDDDDDDD, 0);
        add(0, 0, I, 0, I,                    1, 32'hCCCCCCCC, 0);
        add(0, 0, I, 0, I,                    0, 32'h0, 0);
        // Skew: lane 1 two cycles early
        add(0, 0, I, 1, 32'h00000004,         0, 32'h0, 0);
        add(0, 0, I, 0, I,                    0, 32'h0, 0);
        add(0, 1, 32'h00000003, 0, I,         0, 32'h0, 0);
        add(0, 0, I, 0, I,                    1, 32'h00000003, 0);
        add(0, 0, I, 0, I,                    1, 32'h00000004, 0);
        add(0, 0, I, 0, I,                    0, 32'h0, 0);
        // Lane 1 starvation
        add(0, 1, 32'hAAAAAAAA, 0, I,         0, 32'h0, 0);
        add(0, 1, 32'h00000005, 0, I,         1, 32'hAAAAAAAA, 0);
        add(0, 0, I, 0, I,                    0, 32'h0, 0);
        add(0, 0, I, 0, I,                    0, 32'h0, 0);
        add(0, 0, I, 1, 32'h00000077,         0, 32'h0, 0);
        add(0, 0, I, 0, I,                    1, 32'h00000077, 0);
        add(0, 0, I, 0, I,                    1, 32'h00000005, 0);
        add(0, 0, I, 0, I,                    0, 32'h0, 0);
        // Full F0 with simultaneous pop, then a true drop, then drain across the wrap
        add(1, 0, I, 0, I,                    0, 32'h0, 0);
        add(0, 1, 32'hA0000001, 0, I,         0, 32'h0, 0);
        add(0, 1, 32'hA0000002, 0, I,         1, 32'hA0000001, 0);
        add(0, 1, 32'hA0000003, 0, I,         0, 32'h0, 0);
        add(0, 1, 32'hA0000004, 0, I,         0, 32'h0, 0);
        add(0, 1, 32'hA0000005, 1, 32'hB0000001, 0, 32'h0, 0);
        add(0, 0, I, 0, I,                    1, 32'hB0000001, 0);
        add(0, 1, 32'hA0000006, 0, I,         1, 32'hA0000002, 0);
        add(0, 1, 32'hA0000007, 0, I,         0, 32'h0, 1);
        add(0, 0, I, 1, 32'hB0000002,         0, 32'h0, 1);
        add(0, 0, I, 1, 32'hB0000003,         1, 32'hB0000002, 1);
        add(0, 0, I, 1, 32'hB0000004,         1, 32'hA0000003, 1);
        add(0, 0, I, 1, 32'hB0000005,         1, 32'hB0000003, 1);
        add(0, 0, I, 0, I,                    1, 32'hA0000004, 1);
        add(0, 0, I, 0, I,                    1, 32'hB0000004, 1);
        add(0, 0, I, 0, I,                    1, 32'hA0000005, 1);
        add(0, 0, I, 0, I,                    1, 32'hB0000005, 1);
        add(0, 0, I, 0, I,                    1, 32'hA0000006, 1);
        add(0, 0, I, 0, I,                    0, 32'h0, 1);

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].v0, vecs[i].l0, vecs[i].v1, vecs[i].l1);
            check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].eo);
        end

        // Overflow: lane 0 pushes 1..6 back to back, lane 1 idle
        apply(1, 0, I, 0, I);
        check("ovf_reset", 0, 32'h0, 0);
        for (int k = 1; k <= 6; k++) begin
            apply(0, 1, 32'(k), 0, I);
            check($sformatf("ovf_push%0d", k), (k == 2), (k == 2) ? 32'h1 : 32'h0, (k == 6));
        end
        apply(0, 0, I, 0, I);
        check("ovf_sticky0", 0, 32'h0, 1);
        apply(0, 0, I, 0, I);
        check("ovf_sticky1", 0, 32'h0, 1);

        // Mid-stream reset: FSM in SEL1, F0 holds 2..5, F1 gets one word
        apply(0, 0, I, 1, 32'h00000022);
        check("mid_prefill", 0, 32'h0, 1);
        apply(1, 1, 32'h00000099, 1, 32'h00000098);
        check("mid_reset", 0, 32'h0, 0);
        apply(0, 1, 32'h00000005, 0, I);
        check("mid_push0", 0, 32'h0, 0);
        apply(0, 0, I, 1, 32'h00000066);
        check("mid_out0", 1, 32'h00000005, 0);
        apply(0, 0, I, 0, I);
        check("mid_out1", 1, 32'h00000066, 0);
        apply(0, 0, I, 0, I);
        check("mid_quiet0", 0, 32'h0, 0);
        apply(0, 0, I, 0, I);
        check("mid_quiet1", 0, 32'h0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
